guess_entry: RTL and testbench
==============================

Name: guess_entry

Overview:
- Upstream stage of the 1A2B game core. Converts raw active-low push-buttons and a 4-bit switch digit into a validated 4-digit BCD guess.
- A valid guess has four decimal digits that are pairwise distinct. The block presents it to the game core with a valid/accept handshake.
- Also drives a live entry display word and an error code for the 7-segment and LED layer.

Parameters:
- DEBOUNCE_CYCLES, 1000, consecutive cycles a raw key must differ from its debounced level before the debounced level follows it (minimum 2).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- key_digit_n  input  1  raw button, active-low: enter sw_digit
- key_back_n  input  1  raw button, active-low: delete last digit
- key_submit_n  input  1  raw button, active-low: submit guess
- sw_digit  input  4  digit value from switches, sampled on the digit press event
- accept  input  1  game core takes guess; meaningful only while guess_valid=1
- guess  output  16  submitted guess, first-entered digit in [15:12]
- guess_valid  output  1  guess held and stable until accepted
- digit_count  output  3  digits currently entered, 0..4
- err_code  output  2  0 none, 1 digit>9, 2 duplicate digit, 3 submit with fewer than 4 digits
- entry_disp  output  16  entry buffer; unfilled nibbles read 4'hF

Behaviour:
- Reset, asynchronous and active-low, sets:
  - buffer/entry_disp to 16'hFFFF; digit_count 0; guess 16'h0000; guess_valid 0; err_code 0; state ENTRY.
  - All three debounced levels to 1 (released) and all debounce counters to 0.
  - Reset mid-entry or mid-HOLD discards everything; no event is generated on reset release.
- Debounce, one instance per key:
  - Counter increments each cycle raw != debounced and clears to 0 when they match.
  - On the edge where a mismatch has lasted DEBOUNCE_CYCLES cycles, debounced <= raw and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Press event: debounced level is 0 and its one-cycle-delayed copy is 1. Exactly one event per press; release produces nothing.
- Action timing: the action is registered on the edge ending the event cycle. Outputs change DEBOUNCE_CYCLES+1 edges after raw is first sampled low.
- Simultaneous events in one cycle: priority submit > back > digit. Lower-priority events are dropped.
- State ENTRY:
  - Digit event:
    - sw_digit>9: err_code<=1, buffer unchanged.
    - sw_digit equals any filled nibble: err_code<=2, buffer unchanged.
    - digit_count==4: ignored, err_code unchanged.
    - Otherwise: buffer <= {buffer[11:0], sw_digit}, digit_count+1, err_code<=0.
    - The F padding never matches a legal digit, so the duplicate check may compare all four nibbles.
    - Entered digits are right-aligned: after two digits 1,2, buffer = 16'hFF12.
  - Back event:
    - digit_count>0: buffer <= {4'hF, buffer[15:4]}, digit_count-1, err_code<=0.
    - digit_count==0: no change.
  - Submit event:
    - digit_count==4: guess<=buffer, guess_valid<=1, err_code<=0, go to HOLD.
    - Otherwise: err_code<=3, nothing else changes.
- State HOLD:
  - guess and guess_valid are held; all key events are ignored, but debouncers keep running.
  - On the edge where accept=1: guess_valid<=0, buffer<=16'hFFFF, digit_count<=0, go to ENTRY. guess keeps its last value.
  - accept is ignored in ENTRY.
  - Earliest accept is the first cycle guess_valid reads 1. One accepted guess per submission.
- err_code is sticky until the next action that clears it or reset.

Test Plan:
- DEBOUNCE_CYCLES=4, reset, key_digit_n low for 3 cycles then high -> no change, digit_count 0, entry_disp 16'hFFFF.
- Digits 1,2,3,4 each held 10 cycles -> entry_disp 16'h1234, digit_count 4. Update lands exactly 5 edges after the first low sample.
- Enter 5, then sw_digit=5 again, then sw_digit=12 -> err_code 2 then 1. entry_disp stays 16'hFFF5.
- Enter 7,8, back, submit -> entry_disp 16'hFFF7, digit_count 1, err_code 3, guess_valid 0.
- Enter 9,0,3,6, submit, accept held low 20 cycles with extra digit presses -> guess 16'h9036, guess_valid 1 throughout, buffer unchanged. Then accept=1 for one cycle -> guess_valid 0, digit_count 0, entry_disp 16'hFFFF.
- Submit and digit debounced on the same cycle with digit_count 4 -> submit wins, guess_valid 1. Then assert rst_n=0 mid-HOLD -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/guess_entry_if.sv
// Bundles the key/switch inputs, the game-core handshake and the display
// outputs of the guess entry stage.
//
// Handshake: guess_valid is raised with guess and both stay stable until the
// consumer drives accept=1 on a rising edge while guess_valid=1; that edge
// completes the transfer and drops guess_valid. accept has no effect while
// guess_valid=0.
interface guess_entry_if;
  logic        key_digit_n;
  logic        key_back_n;
  logic        key_submit_n;
  logic [3:0]  sw_digit;
  logic        accept;
  logic [15:0] guess;
  logic        guess_valid;
  logic [2:0]  digit_count;
  logic [1:0]  err_code;
  logic [15:0] entry_disp;
  logic        state_dbg;   // 0 ENTRY, 1 HOLD

  modport master (
    output key_digit_n, key_back_n, key_submit_n, sw_digit, accept,
    input  guess, guess_valid, digit_count, err_code, entry_disp, state_dbg
  );

  modport slave (
    input  key_digit_n, key_back_n, key_submit_n, sw_digit, accept,
    output guess, guess_valid, digit_count, err_code, entry_disp, state_dbg
  );
endinterface

// File: rtl/guess_entry.sv
// Guess entry stage for the 1A2B game: debounces three active-low keys,
// builds a right-aligned 4-digit BCD entry with range and duplicate checks,
// and hands a complete guess to the game core over a valid/accept handshake.
module guess_entry #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic           clk,
  input  logic           rst_n,
  guess_entry_if.slave   bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Key index: 0 digit, 1 back, 2 submit
  localparam int K_DIGIT  = 0;
  localparam int K_BACK   = 1;
  localparam int K_SUBMIT = 2;

  typedef enum logic {
    ENTRY = 1'b0,
    HOLD  = 1'b1
  } state_e;

  logic [2:0]    raw;
  logic [2:0]    deb_q, deb_d;
  logic [2:0]    deb_dly_q;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  logic [2:0]    evt;

  state_e        state_q, state_d;
  logic [15:0]   buf_q, buf_d;
  logic [2:0]    count_q, count_d;
  logic [15:0]   guess_q, guess_d;
  logic          valid_q, valid_d;
  logic [1:0]    err_q, err_d;
  logic          dup;

  assign raw = {bus.key_submit_n, bus.key_back_n, bus.key_digit_n};

  // Debounce: count consecutive mismatch cycles, follow raw once the count
  // reaches DEBOUNCE_CYCLES, otherwise hold the debounced level.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (raw[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = raw[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounced levels reset released, so reset release never creates an event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q     <= 3'b111;
      deb_dly_q <= 3'b111;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // A press is the falling edge of the debounced (active-low) level
  assign evt = deb_dly_q & ~deb_q;

  // Unfilled nibbles hold 4'hF, which can never equal a digit that already
  // passed the >9 check, so all four nibbles are compared unconditionally.
  assign dup = (buf_q[15:12] == bus.sw_digit) || (buf_q[11:8] == bus.sw_digit) ||
               (buf_q[7:4]   == bus.sw_digit) || (buf_q[3:0]  == bus.sw_digit);

  // Next-state logic for entry editing and the guess handshake;
  // submit outranks back, back outranks digit.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    count_d = count_q;
    guess_d = guess_q;
    valid_d = valid_q;
    err_d   = err_q;
    case (state_q)
      ENTRY: begin
        if (evt[K_SUBMIT]) begin
          if (count_q == 3'd4) begin
            guess_d = buf_q;
            valid_d = 1'b1;
            err_d   = 2'd0;
            state_d = HOLD;
          end else begin
            err_d = 2'd3;
          end
        end else if (evt[K_BACK]) begin
          if (count_q != 3'd0) begin
            buf_d   = {4'hF, buf_q[15:4]};
            count_d = count_q - 3'd1;
            err_d   = 2'd0;
          end
        end else if (evt[K_DIGIT]) begin
          if (bus.sw_digit > 4'd9) begin
            err_d = 2'd1;
          end else if (dup) begin
            err_d = 2'd2;
          end else if (count_q != 3'd4) begin
            buf_d   = {buf_q[11:0], bus.sw_digit};
            count_d = count_q + 3'd1;
            err_d   = 2'd0;
          end
        end
      end
      HOLD: begin
        if (bus.accept) begin
          valid_d = 1'b0;
          buf_d   = 16'hFFFF;
          count_d = 3'd0;
          state_d = ENTRY;
        end
      end
      default: state_d = ENTRY;
    endcase
  end

  // Entry FSM state and its registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENTRY;
      buf_q   <= 16'hFFFF;
      count_q <= 3'd0;
      guess_q <= 16'h0000;
      valid_q <= 1'b0;
      err_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      count_q <= count_d;
      guess_q <= guess_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.guess       = guess_q;
  assign bus.guess_valid = valid_q;
  assign bus.digit_count = count_q;
  assign bus.err_code    = err_q;
  assign bus.entry_disp  = buf_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_guess_entry.sv
// Directed bench for guess_entry with DEBOUNCE_CYCLES=4.
module tb_guess_entry;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_checks;

  guess_entry_if gif();

  guess_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (gif.slave)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1ns past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0: gif.key_digit_n  = v;
      1: gif.key_back_n   = v;
      default: gif.key_submit_n = v;
    endcase
  endtask

  // Driver: one clean press of key k (0 digit, 1 back, 2 submit)
  task automatic press(input int k, input logic [3:0] d);
    gif.sw_digit = d;
    set_key(k, 1'b0);
    tick(10);
    set_key(k, 1'b1);
    tick(8);
  endtask

  task automatic do_reset();
    gif.key_digit_n  = 1'b1;
    gif.key_back_n   = 1'b1;
    gif.key_submit_n = 1'b1;
    gif.sw_digit     = 4'd0;
    gif.accept       = 1'b0;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (gif.entry_disp !== 16'hFFFF) $display("FAIL reset_disp got %h exp ffff", gif.entry_disp); else n_pass++;
    n_checks++; if (gif.digit_count !== 3'd0) $display("FAIL reset_count got %0d exp 0", gif.digit_count); else n_pass++;
    n_checks++; if (gif.guess !== 16'h0000) $display("FAIL reset_guess got %h exp 0000", gif.guess); else n_pass++;
    n_checks++; if (gif.guess_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", gif.guess_valid); else n_pass++;
    n_checks++; if (gif.err_code !== 2'd0) $display("FAIL reset_err got %0d exp 0", gif.err_code); else n_pass++;
    n_checks++; if (gif.state_dbg !== 1'b0) $display("FAIL reset_state got %b exp 0", gif.state_dbg); else n_pass++;
  endtask

  task automatic test_glitch();
    gif.sw_digit = 4'd3;
    gif.key_digit_n = 1'b0;
    tick(3);
    gif.key_digit_n = 1'b1;
    tick(10);
    n_checks++; if (gif.digit_count !== 3'd0) $display("FAIL glitch_count got %0d exp 0", gif.digit_count); else n_pass++;
    n_checks++; if (gif.entry_disp !== 16'hFFFF) $display("FAIL glitch_disp got %h exp ffff", gif.entry_disp); else n_pass++;
  endtask

  task automatic test_digits();
    do_reset();
    gif.sw_digit = 4'd1;
    gif.key_digit_n = 1'b0;
    tick(4);
    n_checks++; if (gif.entry_disp !== 16'hFFFF) $display("FAIL timing_early got %h exp ffff", gif.entry_disp); else n_pass++;
    tick(1);
    n_checks++; if (gif.entry_disp !== 16'hFFF1) $display("FAIL timing_edge5 got %h exp fff1", gif.entry_disp); else n_pass++;
    n_checks++; if (gif.digit_count !== 3'd1) $display("FAIL timing_count got %0d exp 1", gif.digit_count); else n_pass++;
    tick(5);
    gif.key_digit_n = 1'b1;
    tick(8);
    press(0, 4'd2);
    n_checks++; if (gif.entry_disp !== 16'hFF12) $display("FAIL digits_align got %h exp ff12", gif.entry_disp); else n_pass++;
    press(0, 4'd3);
    press(0, 4'd4);
    n_checks++; if (gif.entry_disp !== 16'h1234) $display("FAIL digits_disp got %h exp 1234", gif.entry_disp); else n_pass++;
    n_checks++; if (gif.digit_count !== 3'd4) $display("FAIL digits_count got %0d exp 4", gif.digit_count); else n_pass++;
    press(0, 4'd5);
    n_checks++; if (gif.entry_disp !== 16'h1234) $display("FAIL digits_full_disp got %h exp 1234", gif.entry_disp); else n_pass++;
    n_checks++; if (gif.err_code !== 2'd0) $display("FAIL digits_full_err got %0d exp 0", gif.err_code); else n_pass++;
  endtask

  task automatic test_errors();
    do_reset();
    press(0, 4'd5);
    n_checks++; if (gif.entry_disp !== 16'hFFF5) $display("FAIL err_first got %h exp fff5", gif.entry_disp); else n_pass++;
    press(0, 4'd5);
    n_checks++; if (gif.err_code !== 2'd2) $display("FAIL err_dup got %0d exp 2", gif.err_code); else n_pass++;
    n_checks++; if (gif.entry_disp !== 16'hFFF5) $display("FAIL err_dup_disp got %h exp fff5", gif.entry_disp); else n_pass++;
    press(0, 4'd12);
    n_checks++; if (gif.err_code !== 2'd1) $display("FAIL err_range got %0d exp 1", gif.err_code); else n_pass++;
    n_checks++; if (gif.entry_disp !== 16'hFFF5) $display("FAIL err_range_disp got %h exp fff5", gif.entry_disp); else n_pass++;
    n_checks++; if (gif.digit_count !== 3'd1) $display("FAIL err_count got %0d exp 1", gif.digit_count); else n_pass++;
  endtask

  task automatic test_back_submit();
    do_reset();
    press(0, 4'd7);
    press(0, 4'd8);
    n_checks++; if (gif.entry_disp !== 16'hFF78) $display("FAIL back_pre got %h exp ff78", gif.entry_disp); else n_pass++;
    press(1, 4'd0);
    n_checks++; if (gif.entry_disp !== 16'hFFF7) $display("FAIL back_disp got %h exp fff7", gif.entry_disp); else n_pass++;
    press(2, 4'd0);
    n_checks++; if (gif.err_code !== 2'd3) $display("FAIL short_submit_err got %0d exp 3", gif.err_code); else n_pass++;
    n_checks++; if (gif.guess_valid !== 1'b0) $display("FAIL short_submit_valid got %b exp 0", gif.guess_valid); else n_pass++;
    n_checks++; if (gif.entry_disp !== 16'hFFF7) $display("FAIL short_submit_disp got %h exp fff7", gif.entry_disp); else n_pass++;
    n_checks++; if (gif.digit_count !== 3'd1) $display("FAIL short_submit_count got %0d exp 1", gif.digit_count); else n_pass++;
    press(1, 4'd0);
    press(1, 4'd0);
    n_checks++; if (gif.digit_count !== 3'd0) $display("FAIL back_empty_count got %0d exp 0", gif.digit_count); else n_pass++;
    n_checks++; if (gif.entry_disp !== 16'hFFFF) $display("FAIL back_empty_disp got %h exp ffff", gif.entry_disp); else n_pass++;
  endtask

  task automatic test_hold();
    do_reset();
    press(0, 4'd9);
    press(0, 4'd0);
    press(0, 4'd3);
    press(0, 4'd6);
    press(2, 4'd0);
    n_checks++; if (gif.guess_valid !== 1'b1) $display("FAIL hold_valid got %b exp 1", gif.guess_valid); else n_pass++;
    n_checks++; if (gif.guess !== 16'h9036) $display("FAIL hold_guess got %h exp 9036", gif.guess); else n_pass++;
    n_checks++; if (gif.state_dbg !== 1'b1) $display("FAIL hold_state got %b exp 1", gif.state_dbg); else n_pass++;
    // Key activity while accept stays low must not disturb anything
    gif.sw_digit = 4'd1;
    gif.key_digit_n = 1'b0;
    gif.key_back_n  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        gif.key_digit_n = 1'b1;
        gif.key_back_n  = 1'b1;
      end
      tick(1);
      n_checks++; if (gif.guess_valid !== 1'b1) $display("FAIL hold_stable_valid cyc %0d got %b exp 1", i, gif.guess_valid); else n_pass++;
    end
    n_checks++; if (gif.entry_disp !== 16'h9036) $display("FAIL hold_disp got %h exp 9036", gif.entry_disp); else n_pass++;
    n_checks++; if (gif.digit_count !== 3'd4) $display("FAIL hold_count got %0d exp 4", gif.digit_count); else n_pass++;
    gif.accept = 1'b1;
    tick(1);
    gif.accept = 1'b0;
    n_checks++; if (gif.guess_valid !== 1'b0) $display("FAIL accept_valid got %b exp 0", gif.guess_valid); else n_pass++;
    n_checks++; if (gif.digit_count !== 3'd0) $display("FAIL accept_count got %0d exp 0", gif.digit_count); else n_pass++;
    n_checks++; if (gif.entry_disp !== 16'hFFFF) $display("FAIL accept_disp got %h exp ffff", gif.entry_disp); else n_pass++;
    n_checks++; if (gif.guess !== 16'h9036) $display("FAIL accept_guess got %h exp 9036", gif.guess); else n_pass++;
    n_checks++; if (gif.state_dbg !== 1'b0) $display("FAIL accept_state got %b exp 0", gif.state_dbg); else n_pass++;
    gif.accept = 1'b1;
    tick(3);
    gif.accept = 1'b0;
    n_checks++; if (gif.guess_valid !== 1'b0) $display("FAIL accept_entry_ignored got %b exp 0", gif.guess_valid); else n_pass++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    press(0, 4'd1);
    press(0, 4'd2);
    press(0, 4'd3);
    press(0, 4'd4);
    gif.sw_digit = 4'd5;
    gif.key_digit_n  = 1'b0;
    gif.key_submit_n = 1'b0;
    tick(5);
    n_checks++; if (gif.guess_valid !== 1'b1) $display("FAIL simul_valid got %b exp 1", gif.guess_valid); else n_pass++;
    n_checks++; if (gif.guess !== 16'h1234) $display("FAIL simul_guess got %h exp 1234", gif.guess); else n_pass++;
    n_checks++; if (gif.entry_disp !== 16'h1234) $display("FAIL simul_disp got %h exp 1234", gif.entry_disp); else n_pass++;
    // Asynchronous reset in HOLD, observed before any clock edge
    rst_n = 1'b0;
    #1;
    n_checks++; if (gif.guess_valid !== 1'b0) $display("FAIL areset_valid got %b exp 0", gif.guess_valid); else n_pass++;
    n_checks++; if (gif.guess !== 16'h0000) $display("FAIL areset_guess got %h exp 0000", gif.guess); else n_pass++;
    n_checks++; if (gif.entry_disp !== 16'hFFFF) $display("FAIL areset_disp got %h exp ffff", gif.entry_disp); else n_pass++;
    n_checks++; if (gif.digit_count !== 3'd0) $display("FAIL areset_count got %0d exp 0", gif.digit_count); else n_pass++;
    n_checks++; if (gif.state_dbg !== 1'b0) $display("FAIL areset_state got %b exp 0", gif.state_dbg); else n_pass++;
    gif.key_digit_n  = 1'b1;
    gif.key_submit_n = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    n_checks++; if (gif.digit_count !== 3'd0) $display("FAIL post_reset_count got %0d exp 0", gif.digit_count); else n_pass++;
    n_checks++; if (gif.err_code !== 2'd0) $display("FAIL post_reset_err got %0d exp 0", gif.err_code); else n_pass++;
  endtask

  // Sequencer and final report
  initial begin
    n_pass   = 0;
    n_checks = 0;
    rst_n    = 1'b0;
    test_reset();
    test_glitch();
    test_digits();
    test_errors();
    test_back_submit();
    test_hold();
    test_simultaneous();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
